// File: rtl/i2c_reg16_slave.sv
// I2C target for the 16-bit pointer / 16-bit data register protocol, backed by a 16-word register file.
// Define I2C_REG16_SLAVE_AUTOINC_EN to advance POINTER by 2 after every written or master-ACKed read word.
module i2c_reg16_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h0E,
  parameter logic [15:0] CHIP_ID    = 16'h4401
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic        WR_STROBE,
  output logic [15:0] WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic [15:0] POINTER,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_MACK, IGNORE
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_hist, sda_hist;
  logic        sda_oe;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sh;
  logic [7:0]  tx_sh;
  logic [15:0] tx_word;
  logic        tx_lo;
  logic [2:0]  byte_idx;
  logic [7:0]  ptr_hi, data_hi;
  logic        ack_on, rw, mack_ok;
  logic [15:0] regs [0:15];

  logic        scl_now, sda_now, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte_v;
  logic [15:0] rd_cur;

  assign scl_now   = scl_sync[1];
  assign sda_now   = sda_sync[1];
  assign scl_rise  = scl_now & ~scl_hist;
  assign scl_fall  = ~scl_now & scl_hist;
  assign start_det = scl_now & scl_hist & sda_hist & ~sda_now;
  assign stop_det  = scl_now & scl_hist & ~sda_hist & sda_now;
  assign rx_byte_v = {rx_sh, sda_now};
  assign I2C_SDA   = sda_oe ? 1'b0 : 1'bz;

  // Word 0 is the read-only ID; anything at or above 0x20 reads as zero.
  assign rd_cur = (POINTER >= 16'h0020) ? 16'h0000 :
                  (POINTER[4:1] == 4'd0) ? CHIP_ID : regs[POINTER[4:1]];

`ifdef I2C_REG16_SLAVE_AUTOINC_EN
  logic [15:0] ptr_inc, rd_inc;
  assign ptr_inc = POINTER + 16'd2;
  assign rd_inc  = (ptr_inc >= 16'h0020) ? 16'h0000 :
                   (ptr_inc[4:1] == 4'd0) ? CHIP_ID : regs[ptr_inc[4:1]];
`endif

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      state     <= IDLE;
      sda_oe    <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sh     <= 7'd0;
      tx_sh     <= 8'd0;
      tx_word   <= 16'd0;
      tx_lo     <= 1'b0;
      byte_idx  <= 3'd0;
      ptr_hi    <= 8'd0;
      data_hi   <= 8'd0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      mack_ok   <= 1'b0;
      POINTER   <= 16'd0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= 16'd0;
      WR_DATA   <= 16'd0;
      BUSY      <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
    end else begin
      scl_sync  <= {scl_sync[0], I2C_SCL};
      sda_sync  <= {sda_sync[0], I2C_SDA};
      scl_hist  <= scl_sync[1];
      sda_hist  <= sda_sync[1];
      WR_STROBE <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        BUSY   <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        BUSY    <= 1'b1;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            rx_sh   <= rx_byte_v[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte_v[7:1] == SLAVE_ADDR) begin
                state   <= ADDR_ACK;
                rw      <= rx_byte_v[0];
                ack_on  <= 1'b0;
                tx_word <= rd_cur;
                tx_sh   <= rd_cur[15:8];
                tx_lo   <= 1'b0;
              end else begin
                state <= IGNORE;
              end
            end
          end
          // First falling edge starts the ACK, the second ends it.
          ADDR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              if (rw) begin
                state  <= TX_BYTE;
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
              end else begin
                state    <= RX_BYTE;
                sda_oe   <= 1'b0;
                byte_idx <= 3'd0;
              end
            end
          end
          RX_BYTE: if (scl_rise) begin
            rx_sh   <= rx_byte_v[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state  <= RX_ACK;
              ack_on <= 1'b0;
              case (byte_idx)
                3'd0: begin ptr_hi <= rx_byte_v; byte_idx <= 3'd1; end
                3'd1: begin POINTER <= {ptr_hi, rx_byte_v}; byte_idx <= 3'd2; end
                3'd2: begin data_hi <= rx_byte_v; byte_idx <= 3'd3; end
                3'd3: begin
                  if (POINTER < 16'h0020 && POINTER[4:1] != 4'd0)
                    regs[POINTER[4:1]] <= {data_hi, rx_byte_v};
                  WR_STROBE <= 1'b1;
                  WR_ADDR   <= POINTER;
                  WR_DATA   <= {data_hi, rx_byte_v};
`ifdef I2C_REG16_SLAVE_AUTOINC_EN
                  POINTER   <= ptr_inc;
                  byte_idx  <= 3'd2;
`else
                  byte_idx  <= 3'd4;
`endif
                end
                default: ;
              endcase
            end
          end
          RX_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= RX_BYTE;
            end
          end
          TX_BYTE: if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe  <= 1'b0;
              mack_ok <= 1'b0;
              state   <= TX_MACK;
            end else begin
              sda_oe <= ~tx_sh[7];
              tx_sh  <= {tx_sh[6:0], 1'b0};
            end
          end
          // Next byte is prepared on the ACK rising edge so its MSB is ready at the following fall.
          TX_MACK: begin
            if (scl_rise) begin
              if (sda_now) begin
                state <= IGNORE;
              end else begin
                mack_ok <= 1'b1;
                if (!tx_lo) begin
                  tx_sh <= tx_word[7:0];
                  tx_lo <= 1'b1;
                end else begin
                  tx_lo <= 1'b0;
`ifdef I2C_REG16_SLAVE_AUTOINC_EN
                  POINTER <= ptr_inc;
                  tx_word <= rd_inc;
                  tx_sh   <= rd_inc[15:8];
`else
                  tx_sh   <= tx_word[15:8];
`endif
                end
              end
            end else if (scl_fall && mack_ok) begin
              mack_ok <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= TX_BYTE;
              sda_oe  <= ~tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg16_slave.sv
// Bench for i2c_reg16_slave: bit-banged I2C master plus a word-level model of the register map.
module tb_i2c_reg16_slave;
  localparam int QTR  = 100;
  localparam int HALF = 200;

  logic        clk = 1'b0;
  logic        rst_n, scl, m_low;
  wire         sda_bus;
  logic        wr_strobe, busy;
  logic [15:0] wr_addr, wr_data, pointer;

  int          vectors = 0;
  int          miscompares = 0;
  int          strobes = 0;
  logic [15:0] model_mem [0:15];
  logic [15:0] model_ptr;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_reg16_slave dut (
    .CLK_50(clk), .RESET_N(rst_n), .I2C_SCL(scl), .I2C_SDA(sda_bus),
    .WR_STROBE(wr_strobe), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .POINTER(pointer), .BUSY(busy)
  );

  always #10 clk = ~clk;
  always @(negedge clk) if (wr_strobe === 1'b1) strobes++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_read(input logic [15:0] p);
    int w;
    w = int'(p) / 2;
    if (p >= 16'h0020) return 16'h0000;
    if (w == 0) return 16'h4401;
    return model_mem[w];
  endfunction

  task automatic model_store(input logic [15:0] p, input logic [15:0] d);
    int w;
    w = int'(p) / 2;
    if (p < 16'h0020 && w != 0) model_mem[w] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    model_ptr = 16'h0000;
  endtask

  task automatic model_word_write(input logic [15:0] p, input logic [15:0] d);
    model_store(p, d);
`ifdef I2C_REG16_SLAVE_AUTOINC_EN
    model_ptr = p + 16'd2;
`else
    model_ptr = p;
`endif
  endtask

  // Two words read with master ACK between them.
  task automatic model_word_read(input logic [15:0] p, output logic [15:0] e1, output logic [15:0] e2);
    logic [15:0] q;
    e1 = model_read(p);
`ifdef I2C_REG16_SLAVE_AUTOINC_EN
    q = p + 16'd2;
    e2 = model_read(q);
    model_ptr = q;
`else
    e2 = e1;
    model_ptr = p;
`endif
  endtask

  // ---------------- bus master ----------------
  task automatic bus_start();
    m_low = 1'b0; #QTR; scl = 1'b1; #HALF; m_low = 1'b1; #QTR; scl = 1'b0; #QTR;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #QTR; scl = 1'b1; #QTR; m_low = 1'b0; #HALF;
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #QTR; scl = 1'b1; #HALF; scl = 1'b0; #QTR;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #QTR; scl = 1'b1; #QTR; b = sda_bus; #QTR; scl = 1'b0; #QTR;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    acked = (a === 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    write_bit(~mack);
  endtask

  task automatic do_write(input logic [15:0] p, input logic [15:0] d, output int nacks);
    logic a;
    nacks = 0;
    bus_start();
    write_byte(8'h1C, a);    if (!a) nacks++;
    write_byte(p[15:8], a);  if (!a) nacks++;
    write_byte(p[7:0], a);   if (!a) nacks++;
    write_byte(d[15:8], a);  if (!a) nacks++;
    write_byte(d[7:0], a);   if (!a) nacks++;
    bus_stop();
  endtask

  task automatic do_read(input logic [15:0] p, output logic [15:0] w1, output logic [15:0] w2, output int nacks);
    logic a;
    logic [7:0] b;
    nacks = 0;
    bus_start();
    write_byte(8'h1C, a);    if (!a) nacks++;
    write_byte(p[15:8], a);  if (!a) nacks++;
    write_byte(p[7:0], a);   if (!a) nacks++;
    bus_start();
    write_byte(8'h1D, a);    if (!a) nacks++;
    read_byte(b, 1'b1); w1[15:8] = b;
    read_byte(b, 1'b1); w1[7:0]  = b;
    read_byte(b, 1'b1); w2[15:8] = b;
    read_byte(b, 1'b0); w2[7:0]  = b;
    bus_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    scl = 1'b1; m_low = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
    vectors++; if (pointer !== 16'h0000) begin miscompares++; $display("FAIL reset_pointer got %h exp 0000", pointer); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (wr_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got %b exp 0", wr_strobe); end
    vectors++; if (wr_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_wr_addr got %h exp 0000", wr_addr); end
    vectors++; if (wr_data !== 16'h0000) begin miscompares++; $display("FAIL reset_wr_data got %h exp 0000", wr_data); end
    vectors++; if (sda_bus !== 1'b1) begin miscompares++; $display("FAIL reset_sda got %b exp 1", sda_bus); end
  endtask

  task automatic test_chip_id();
    logic a;
    logic [7:0] b;
    int acks = 0;
    bus_start();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL chipid_busy_start got %b exp 1", busy); end
    write_byte(8'h1C, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    bus_start();
    write_byte(8'h1D, a); if (a) acks++;
    vectors++; if (acks != 4) begin miscompares++; $display("FAIL chipid_acks got %0d exp 4", acks); end
    read_byte(b, 1'b1);
    vectors++; if (b !== 8'h44) begin miscompares++; $display("FAIL chipid_hi got %h exp 44", b); end
    read_byte(b, 1'b0);
    vectors++; if (b !== 8'h01) begin miscompares++; $display("FAIL chipid_lo got %h exp 01", b); end
    bus_stop();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL chipid_busy_stop got %b exp 0", busy); end
    vectors++; if (pointer !== 16'h0000) begin miscompares++; $display("FAIL chipid_pointer got %h exp 0000", pointer); end
  endtask

  task automatic test_write_read();
    int s0, n;
    logic [15:0] w1, w2, e1, e2;
    s0 = strobes;
    do_write(16'h0016, 16'h1027, n);
    model_word_write(16'h0016, 16'h1027);
    vectors++; if (n != 0) begin miscompares++; $display("FAIL wr_nacks got %0d exp 0", n); end
    vectors++; if (strobes - s0 != 1) begin miscompares++; $display("FAIL wr_strobes got %0d exp 1", strobes - s0); end
    vectors++; if (wr_addr !== 16'h0016) begin miscompares++; $display("FAIL wr_addr got %h exp 0016", wr_addr); end
    vectors++; if (wr_data !== 16'h1027) begin miscompares++; $display("FAIL wr_data got %h exp 1027", wr_data); end
    vectors++; if (pointer !== model_ptr) begin miscompares++; $display("FAIL wr_pointer got %h exp %h", pointer, model_ptr); end
    do_read(16'h0016, w1, w2, n);
    model_word_read(16'h0016, e1, e2);
    vectors++; if (w1 !== 16'h1027) begin miscompares++; $display("FAIL rd_word got %h exp 1027", w1); end
    vectors++; if (w2 !== e2) begin miscompares++; $display("FAIL rd_word2 got %h exp %h", w2, e2); end
  endtask

  task automatic test_bad_addr();
    logic a;
    int acks = 0;
    int s0;
    logic [15:0] p0, w1, w2, e1, e2;
    int n;
    p0 = pointer; s0 = strobes;
    bus_start();
    write_byte(8'h3A, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    write_byte(8'h16, a); if (a) acks++;
    write_byte(8'hDE, a); if (a) acks++;
    write_byte(8'hAD, a); if (a) acks++;
    vectors++; if (acks != 0) begin miscompares++; $display("FAIL badaddr_acks got %0d exp 0", acks); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL badaddr_busy got %b exp 1", busy); end
    bus_stop();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badaddr_busy_stop got %b exp 0", busy); end
    vectors++; if (pointer !== p0) begin miscompares++; $display("FAIL badaddr_pointer got %h exp %h", pointer, p0); end
    vectors++; if (strobes != s0) begin miscompares++; $display("FAIL badaddr_strobes got %0d exp %0d", strobes, s0); end
    do_read(16'h0016, w1, w2, n);
    model_word_read(16'h0016, e1, e2);
    vectors++; if (w1 !== e1) begin miscompares++; $display("FAIL badaddr_reg got %h exp %h", w1, e1); end
  endtask

  task automatic test_autoinc();
    logic a;
    int acks = 0;
    int s0, n, exp_strobes;
    logic [15:0] w1, w2, e1, e2;
    s0 = strobes;
    bus_start();
    write_byte(8'h1C, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    write_byte(8'h02, a); if (a) acks++;
    write_byte(8'hAA, a); if (a) acks++;
    write_byte(8'hAA, a); if (a) acks++;
    write_byte(8'h55, a); if (a) acks++;
    write_byte(8'h55, a); if (a) acks++;
    bus_stop();
    model_store(16'h0002, 16'hAAAA);
`ifdef I2C_REG16_SLAVE_AUTOINC_EN
    model_store(16'h0004, 16'h5555);
    model_ptr = 16'h0006;
    exp_strobes = 2;
`else
    model_ptr = 16'h0002;
    exp_strobes = 1;
`endif
    vectors++; if (acks != 7) begin miscompares++; $display("FAIL multi_acks got %0d exp 7", acks); end
    vectors++; if (strobes - s0 != exp_strobes) begin miscompares++; $display("FAIL multi_strobes got %0d exp %0d", strobes - s0, exp_strobes); end
    vectors++; if (pointer !== model_ptr) begin miscompares++; $display("FAIL multi_pointer got %h exp %h", pointer, model_ptr); end
    do_read(16'h0002, w1, w2, n);
    model_word_read(16'h0002, e1, e2);
    vectors++; if (w1 !== e1) begin miscompares++; $display("FAIL multi_reg2 got %h exp %h", w1, e1); end
    vectors++; if (w2 !== e2) begin miscompares++; $display("FAIL multi_next got %h exp %h", w2, e2); end
    do_read(16'h0004, w1, w2, n);
    model_word_read(16'h0004, e1, e2);
    vectors++; if (w1 !== e1) begin miscompares++; $display("FAIL multi_reg4 got %h exp %h", w1, e1); end
  endtask

  task automatic test_stop_after_hi();
    logic a;
    int acks = 0;
    int s0, n;
    logic [15:0] w1, w2, e1, e2;
    s0 = strobes;
    bus_start();
    write_byte(8'h1C, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    write_byte(8'h08, a); if (a) acks++;
    write_byte(8'hBE, a); if (a) acks++;
    bus_stop();
    model_ptr = 16'h0008;
    vectors++; if (acks != 4) begin miscompares++; $display("FAIL stophi_acks got %0d exp 4", acks); end
    vectors++; if (strobes != s0) begin miscompares++; $display("FAIL stophi_strobes got %0d exp %0d", strobes, s0); end
    vectors++; if (pointer !== model_ptr) begin miscompares++; $display("FAIL stophi_pointer got %h exp %h", pointer, model_ptr); end
    do_read(16'h0008, w1, w2, n);
    model_word_read(16'h0008, e1, e2);
    vectors++; if (w1 !== e1) begin miscompares++; $display("FAIL stophi_reg got %h exp %h", w1, e1); end
  endtask

  task automatic test_random();
    logic [15:0] p, d, w1, w2, e1, e2;
    int n, s0;
    for (int it = 0; it < 14; it++) begin
      p = 16'($urandom_range(0, 16'h002F));
      if ($urandom_range(0, 7) == 0) p = 16'hFFFE;
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        s0 = strobes;
        do_write(p, d, n);
        model_word_write(p, d);
        vectors++; if (n != 0) begin miscompares++; $display("FAIL rnd_wr_nacks it=%0d got %0d exp 0", it, n); end
        vectors++; if (strobes - s0 != 1) begin miscompares++; $display("FAIL rnd_wr_strobe it=%0d got %0d exp 1", it, strobes - s0); end
        vectors++; if (wr_addr !== p || wr_data !== d) begin miscompares++; $display("FAIL rnd_wr_out it=%0d got %h/%h exp %h/%h", it, wr_addr, wr_data, p, d); end
      end else begin
        do_read(p, w1, w2, n);
        model_word_read(p, e1, e2);
        vectors++; if (n != 0) begin miscompares++; $display("FAIL rnd_rd_nacks it=%0d got %0d exp 0", it, n); end
        vectors++; if (w1 !== e1) begin miscompares++; $display("FAIL rnd_rd_w1 it=%0d ptr=%h got %h exp %h", it, p, w1, e1); end
        vectors++; if (w2 !== e2) begin miscompares++; $display("FAIL rnd_rd_w2 it=%0d ptr=%h got %h exp %h", it, p, w2, e2); end
      end
      vectors++; if (pointer !== model_ptr) begin miscompares++; $display("FAIL rnd_pointer it=%0d got %h exp %h", it, pointer, model_ptr); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic a, b0, b1;
    logic [7:0] b;
    logic [15:0] id, w1, w2, e1, e2;
    int acks = 0;
    int n;
    id = model_read(16'h0000);
    bus_start();
    write_byte(8'h1C, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    write_byte(8'h00, a); if (a) acks++;
    bus_start();
    write_byte(8'h1D, a); if (a) acks++;
    read_bit(b0);
    read_bit(b1);
    vectors++; if (acks != 4) begin miscompares++; $display("FAIL rstmid_acks got %0d exp 4", acks); end
    vectors++; if ({b0, b1} !== id[15:14]) begin miscompares++; $display("FAIL rstmid_bits got %b%b exp %b", b0, b1, id[15:14]); end
    vectors++; if (sda_bus !== id[13]) begin miscompares++; $display("FAIL rstmid_driven got %b exp %b", sda_bus, id[13]); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_clear();
    vectors++; if (sda_bus !== 1'b1) begin miscompares++; $display("FAIL rstmid_sda_release got %b exp 1", sda_bus); end
    vectors++; if (pointer !== 16'h0000) begin miscompares++; $display("FAIL rstmid_pointer got %h exp 0000", pointer); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    bus_stop();
    acks = 0;
    bus_start();
    write_byte(8'h1D, a); if (a) acks++;
    read_byte(b, 1'b1); w1[15:8] = b;
    read_byte(b, 1'b0); w1[7:0] = b;
    bus_stop();
    vectors++; if (acks != 1) begin miscompares++; $display("FAIL rstmid_post_ack got %0d exp 1", acks); end
    vectors++; if (w1 !== 16'h4401) begin miscompares++; $display("FAIL rstmid_post_id got %h exp 4401", w1); end
    do_read(16'h0016, w1, w2, n);
    model_word_read(16'h0016, e1, e2);
    vectors++; if (w1 !== e1) begin miscompares++; $display("FAIL rstmid_reg_cleared got %h exp %h", w1, e1); end
  endtask

  initial begin
    test_reset();
    test_chip_id();
    test_write_read();
    test_bad_addr();
    test_autoinc();
    test_stop_after_hi();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
